div_operand_sequencer: RTL and testbench

- Upstream front-end for the 4-bit quotient/remainder divider stage.
- Captures dividend then divisor from a shared switch bus on successive Load presses, and rejects a zero divisor.
- Issues exactly one single-cycle Go pulse with stable operands, then waits out the divider latency and signals Done.
- Synchronises and edge-detects the raw Load button internally.

---
 rtl/div_operand_sequencer_if.sv | 48 ++++
 rtl/div_operand_sequencer.sv | 169 ++++++++++++++++
 tb/tb_div_operand_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_operand_sequencer_if.sv
// -----------------------------------------------------------------------------
// div_operand_sequencer_if
//
// Purpose: groups the switch/button inputs and the divider-facing outputs of
// div_operand_sequencer into one bundle. Clock and Resetn stay plain ports on
// the module.
//
// Signals:
//   Load       raw Load button level (asynchronous, active-high)
//   Clear      synchronous abort, active-high
//   Data       operand value from the switches           [WIDTH]
//   Dividend   captured dividend, to the divider          [WIDTH]
//   Divisor    captured divisor, to the divider           [WIDTH]
//   Go         one-cycle start pulse to the divider
//   Done       one-cycle pulse, divider results valid
//   DivByZero  sticky zero-divisor error flag
//   State      current sequencer state (LED display)      [3]
//   OpCount    completed-division counter                 [CNT_W]
//
// Modports:
//   slave  - the sequencer itself (consumes Load/Clear/Data)
//   master - whatever drives the switches/button and watches the results
// -----------------------------------------------------------------------------
interface div_operand_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             Load;
   logic             Clear;
   logic [WIDTH-1:0] Data;
   logic [WIDTH-1:0] Dividend;
   logic [WIDTH-1:0] Divisor;
   logic             Go;
   logic             Done;
   logic             DivByZero;
   logic [2:0]       State;
   logic [CNT_W-1:0] OpCount;

   modport slave (
      input  Load, Clear, Data,
      output Dividend, Divisor, Go, Done, DivByZero, State, OpCount
   );

   modport master (
      output Load, Clear, Data,
      input  Dividend, Divisor, Go, Done, DivByZero, State, OpCount
   );
endinterface

// File: rtl/div_operand_sequencer.sv
// -----------------------------------------------------------------------------
// div_operand_sequencer
//
// Purpose: front-end for the 4-bit quotient/remainder divider. Captures the
// dividend and then the divisor from the shared switch bus on successive Load
// presses, rejects a zero divisor, issues a single Go pulse with stable
// operands, waits out the divider latency and then pulses Done.
//
// Ports:
//   Clock   system clock, rising edge
//   Resetn  synchronous, active-low reset (highest priority)
//   bus     div_operand_sequencer_if.slave
//             in : Load (raw button), Clear (sync abort), Data
//             out: Dividend, Divisor, Go, Done, DivByZero, State, OpCount
//
// Parameters:
//   WIDTH    operand width
//   LATENCY  divider cycles needed after sampling Go (1..15)
//   CNT_W    width of the completed-operation counter
// -----------------------------------------------------------------------------
module div_operand_sequencer #(
   parameter int WIDTH   = 4,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 8
) (
   input  logic                 Clock,
   input  logic                 Resetn,
   div_operand_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_GET_A = 3'd0,
      S_GET_B = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(LATENCY);

   state_t           state_reg,    state_next;
   logic [WIDTH-1:0] dividend_reg, dividend_next;
   logic [WIDTH-1:0] divisor_reg,  divisor_next;
   logic             dbz_reg,      dbz_next;
   logic [CNT_W-1:0] opcount_reg,  opcount_next;
   logic [3:0]       wait_reg,     wait_next;
   logic             go_reg;
   logic             done_reg;

   logic             s1_reg, s2_reg, s3_reg;
   logic             load_rise;

   // Load button: s1/s2 form the metastability synchroniser, s3 is the
   // previous synchronised level for rising-edge detection. A held button
   // therefore yields exactly one load_rise.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         s1_reg <= 1'b0;
         s2_reg <= 1'b0;
         s3_reg <= 1'b0;
      end else begin
         s1_reg <= bus.Load;
         s2_reg <= s1_reg;
         s3_reg <= s2_reg;
      end
   end

   assign load_rise = s2_reg & ~s3_reg;

   // State and datapath registers. Go/Done are registered decodes of the
   // next state, so they are exactly aligned with the state register (Moore
   // behaviour) while coming straight off a flop, free of decode glitches.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_reg    <= S_GET_A;
         dividend_reg <= '0;
         divisor_reg  <= '0;
         dbz_reg      <= 1'b0;
         opcount_reg  <= '0;
         wait_reg     <= '0;
         go_reg       <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         dividend_reg <= dividend_next;
         divisor_reg  <= divisor_next;
         dbz_reg      <= dbz_next;
         opcount_reg  <= opcount_next;
         wait_reg     <= wait_next;
         go_reg       <= (state_next == S_ISSUE);
         done_reg     <= (state_next == S_DONE);
      end
   end

   always_comb begin
      state_next    = state_reg;
      dividend_next = dividend_reg;
      divisor_next  = divisor_reg;
      dbz_next      = dbz_reg;
      opcount_next  = opcount_reg;
      wait_next     = wait_reg;

      if (bus.Clear) begin
         // Abort wins over any concurrent load_rise; OpCount survives, and an
         // in-flight operation never reaches S_DONE so it is not counted.
         state_next    = S_GET_A;
         dividend_next = '0;
         divisor_next  = '0;
         dbz_next      = 1'b0;
      end else begin
         case (state_reg)
            S_GET_A: begin
               if (load_rise) begin
                  dividend_next = bus.Data;
                  state_next    = S_GET_B;
               end
            end
            S_GET_B: begin
               if (load_rise) begin
                  divisor_next = bus.Data;
                  if (bus.Data == '0) begin
                     dbz_next   = 1'b1;
                     state_next = S_ERR;
                  end else begin
                     state_next = S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               wait_next  = WAIT_INIT;
               state_next = S_WAIT;
            end
            S_WAIT: begin
               // Load edges arriving here (and in S_ISSUE/S_DONE) are dropped.
               if (wait_reg == 4'd1) begin
                  state_next   = S_DONE;
                  opcount_next = opcount_reg + 1'b1;
               end else begin
                  wait_next = wait_reg - 4'd1;
               end
            end
            S_DONE: begin
               state_next = S_GET_A;
            end
            S_ERR: begin
               // The press after an error restarts with a fresh dividend.
               if (load_rise) begin
                  dbz_next      = 1'b0;
                  dividend_next = bus.Data;
                  state_next    = S_GET_B;
               end
            end
            default: begin
               state_next = S_GET_A;
            end
         endcase
      end
   end

   assign bus.Dividend  = dividend_reg;
   assign bus.Divisor   = divisor_reg;
   assign bus.Go        = go_reg;
   assign bus.Done      = done_reg;
   assign bus.DivByZero = dbz_reg;
   assign bus.State     = state_reg;
   assign bus.OpCount   = opcount_reg;

endmodule

// File: tb/tb_div_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_operand_sequencer
//
// Two sequencers (LATENCY=1 and LATENCY=3) share one set of button/switch
// stimulus. A cycle-level reference model, written from the operational rules
// (deadline-based Done timing, queue of sampled Load levels), predicts every
// output of both instances each cycle.
// -----------------------------------------------------------------------------
module tb_div_operand_sequencer;

   logic       clock = 1'b0;
   logic       resetn;
   logic       tb_load;
   logic       tb_clear;
   logic [3:0] tb_data;

   always #5 clock = ~clock;

   div_operand_sequencer_if #(.WIDTH(4), .CNT_W(8)) bus1 ();
   div_operand_sequencer_if #(.WIDTH(4), .CNT_W(8)) bus3 ();

   assign bus1.Load  = tb_load;
   assign bus1.Clear = tb_clear;
   assign bus1.Data  = tb_data;
   assign bus3.Load  = tb_load;
   assign bus3.Clear = tb_clear;
   assign bus3.Data  = tb_data;

   div_operand_sequencer #(.WIDTH(4), .LATENCY(1), .CNT_W(8)) u_dut1 (
      .Clock  (clock),
      .Resetn (resetn),
      .bus    (bus1.slave)
   );

   div_operand_sequencer #(.WIDTH(4), .LATENCY(3), .CNT_W(8)) u_dut3 (
      .Clock  (clock),
      .Resetn (resetn),
      .bus    (bus3.slave)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // ---------------- reference model ----------------
   // Phase numbers are the spec's State encoding (0 GET_A .. 5 ERR).
   int lat [2] = '{1, 3};
   int m_phase [2];
   int m_dvd [2];
   int m_dvs [2];
   int m_dbz [2];
   int m_cnt [2];
   int m_done_edge [2];
   int ecount = 0;
   bit ld_q [$];   // sampled Load levels, oldest first; last three are kept

   task automatic model_edge();
      bit rise;
      // Capture happens two edges after Load is first sampled high:
      // the sample two edges ago was high and the one before that was low.
      rise = ld_q[1] && !ld_q[0];
      ecount++;
      if (!resetn) begin
         for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_dvd[k] = 0; m_dvs[k] = 0; m_dbz[k] = 0; m_cnt[k] = 0;
         end
         ld_q = '{1'b0, 1'b0, 1'b0};
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (tb_clear) begin
               m_phase[k] = 0; m_dvd[k] = 0; m_dvs[k] = 0; m_dbz[k] = 0;
            end else begin
               case (m_phase[k])
                  0: if (rise) begin m_dvd[k] = int'(tb_data); m_phase[k] = 1; end
                  1: if (rise) begin
                        m_dvs[k] = int'(tb_data);
                        if (tb_data == 4'd0) begin
                           m_dbz[k] = 1; m_phase[k] = 5;
                        end else begin
                           m_phase[k] = 2;
                           // one cycle of Go, then LATENCY cycles of waiting
                           m_done_edge[k] = ecount + 1 + lat[k];
                        end
                     end
                  2: m_phase[k] = 3;
                  3: if (ecount == m_done_edge[k]) begin
                        m_phase[k] = 4;
                        m_cnt[k] = (m_cnt[k] + 1) % 256;
                        $display("txn lat=%0d dividend=%0d divisor=%0d opcount=%0d",
                                 lat[k], m_dvd[k], m_dvs[k], m_cnt[k]);
                     end
                  4: m_phase[k] = 0;
                  default: if (rise) begin m_dbz[k] = 0; m_dvd[k] = int'(tb_data); m_phase[k] = 1; end
               endcase
            end
         end
         ld_q.push_back(tb_load);
         void'(ld_q.pop_front());
      end
   endtask

   task automatic compare_all();
      logic [31:0] o_state [2], o_dvd [2], o_dvs [2], o_go [2], o_done [2], o_dbz [2], o_cnt [2];
      o_state[0] = 32'(bus1.State);    o_state[1] = 32'(bus3.State);
      o_dvd[0]   = 32'(bus1.Dividend); o_dvd[1]   = 32'(bus3.Dividend);
      o_dvs[0]   = 32'(bus1.Divisor);  o_dvs[1]   = 32'(bus3.Divisor);
      o_go[0]    = 32'(bus1.Go);       o_go[1]    = 32'(bus3.Go);
      o_done[0]  = 32'(bus1.Done);     o_done[1]  = 32'(bus3.Done);
      o_dbz[0]   = 32'(bus1.DivByZero);o_dbz[1]   = 32'(bus3.DivByZero);
      o_cnt[0]   = 32'(bus1.OpCount);  o_cnt[1]   = 32'(bus3.OpCount);
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("lat%0d State @%0d", lat[k], ecount),     o_state[k], 32'(m_phase[k]));
         check_val($sformatf("lat%0d Dividend @%0d", lat[k], ecount),  o_dvd[k],   32'(m_dvd[k]));
         check_val($sformatf("lat%0d Divisor @%0d", lat[k], ecount),   o_dvs[k],   32'(m_dvs[k]));
         check_val($sformatf("lat%0d Go @%0d", lat[k], ecount),        o_go[k],    32'(m_phase[k] == 2));
         check_val($sformatf("lat%0d Done @%0d", lat[k], ecount),      o_done[k],  32'(m_phase[k] == 4));
         check_val($sformatf("lat%0d DivByZero @%0d", lat[k], ecount), o_dbz[k],   32'(m_dbz[k]));
         check_val($sformatf("lat%0d OpCount @%0d", lat[k], ecount),   o_cnt[k],   32'(m_cnt[k]));
      end
   endtask

   // ---------------- stimulus helpers ----------------
   // Inputs change only at the falling edge; outputs are checked there too.
   task automatic cycle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         model_edge();
         @(negedge clock);
         compare_all();
      end
   endtask

   task automatic press(input logic [3:0] d, input int hold);
      tb_data = d;
      tb_load = 1'b1;
      cycle(hold);
      tb_load = 1'b0;
      cycle(3);
   endtask

   // Waits until neither instance is in ISSUE/WAIT/DONE.
   task automatic wait_idle();
      int n;
      bit busy;
      n = 0;
      busy = 1'b1;
      while (busy && n < 100) begin
         busy = 1'b0;
         for (int k = 0; k < 2; k++)
            if (m_phase[k] >= 2 && m_phase[k] <= 4) busy = 1'b1;
         if (busy) begin cycle(1); n++; end
      end
      check_val("idle_wait", 32'(!busy), 32'd1);
   endtask

   task automatic do_div(input logic [3:0] a, input logic [3:0] b);
      press(a, 1);
      press(b, 1);
      wait_idle();
   endtask

   task automatic resync();
      tb_clear = 1'b1;
      cycle(1);
      tb_clear = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [7:0] saved_cnt;
      ld_q = '{1'b0, 1'b0, 1'b0};
      resetn = 1'b0; tb_load = 1'b0; tb_clear = 1'b0; tb_data = 4'd0;
      cycle(3);
      check_val("reset_state", 32'(bus1.State), 32'd0);
      check_val("reset_opcount", 32'(bus3.OpCount), 32'd0);
      resetn = 1'b1;
      cycle(2);

      // Basic division 13 / 4.
      do_div(4'd13, 4'd4);
      check_val("basic_dividend", 32'(bus1.Dividend), 32'd13);
      check_val("basic_divisor", 32'(bus1.Divisor), 32'd4);
      check_val("basic_opcount", 32'(bus1.OpCount), 32'd1);

      // Held Load gives a single capture.
      press(4'd7, 20);
      cycle(4);
      check_val("held_state", 32'(bus1.State), 32'd1);
      check_val("held_dividend", 32'(bus3.Dividend), 32'd7);
      press(4'd3, 1);
      wait_idle();

      // Zero divisor, then recovery.
      press(4'd9, 1);
      press(4'd0, 1);
      cycle(3);
      check_val("dbz_flag", 32'(bus1.DivByZero), 32'd1);
      check_val("dbz_state", 32'(bus3.State), 32'd5);
      press(4'd6, 1);
      check_val("recover_dbz", 32'(bus1.DivByZero), 32'd0);
      check_val("recover_dividend", 32'(bus1.Dividend), 32'd6);
      check_val("recover_state", 32'(bus3.State), 32'd1);
      press(4'd2, 1);
      wait_idle();

      // Extra presses while busy (dropped by the LATENCY=3 instance).
      press(4'd5, 1);
      press(4'd1, 1);
      press(4'd15, 1);
      press(4'd14, 1);
      wait_idle();
      resync();
      do_div(4'd11, 4'd3);

      // Clear during S_WAIT.
      saved_cnt = bus3.OpCount;
      press(4'd8, 1);
      press(4'd3, 1);
      check_val("pre_clear_wait", 32'(bus3.State), 32'd3);
      tb_clear = 1'b1;
      cycle(1);
      tb_clear = 1'b0;
      check_val("clear_state", 32'(bus3.State), 32'd0);
      check_val("clear_dividend", 32'(bus3.Dividend), 32'd0);
      check_val("clear_opcount", 32'(bus3.OpCount), 32'(saved_cnt));
      cycle(6);

      // Reset during S_WAIT.
      press(4'd8, 1);
      press(4'd3, 1);
      resetn = 1'b0;
      cycle(1);
      check_val("midreset_opcount", 32'(bus3.OpCount), 32'd0);
      check_val("midreset_divisor", 32'(bus3.Divisor), 32'd0);
      resetn = 1'b1;
      cycle(4);

      // 256 back-to-back divisions: counter wraps to 0.
      for (int i = 0; i < 256; i++) begin
         if (i == 255) check_val("wrap_pre", 32'(bus1.OpCount), 32'd255);
         do_div(4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)));
      end
      check_val("wrap_lat1", 32'(bus1.OpCount), 32'd0);
      check_val("wrap_lat3", 32'(bus3.OpCount), 32'd0);

      // Randomised button/switch/clear/reset activity.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) tb_load = ~tb_load;
         tb_data  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         tb_clear = ($urandom_range(0, 39) == 0);
         resetn   = !($urandom_range(0, 199) == 0);
         cycle(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
